// File: rtl/arcade_input_ctrl_if.sv
// Bus between user_io-side stimulus and the arcade input front-end.
// Carries joysticks, PS/2 key events, OSD controls and per-player game inputs.
interface arcade_input_ctrl_if #(parameter int PLAYERS = 2);
  logic [32*PLAYERS-1:0] joystick;
  logic                  key_strobe;
  logic                  key_pressed;
  logic [7:0]            key_code;
  logic                  rotate;
  logic [1:0]            orientation;
  logic                  joyswap;
  logic [PLAYERS-1:0]    autofire;
  logic [16*PLAYERS-1:0] player_o;
  logic [PLAYERS-1:0]    start_o;
  logic [PLAYERS-1:0]    coin_o;

  modport master (
    output joystick, key_strobe, key_pressed, key_code, rotate, orientation, joyswap, autofire,
    input  player_o, start_o, coin_o
  );
  modport slave (
    input  joystick, key_strobe, key_pressed, key_code, rotate, orientation, joyswap, autofire,
    output player_o, start_o, coin_o
  );
endinterface

// File: rtl/arcade_input_ctrl.sv
// Arcade control front-end: joystick/keyboard merge, rotation, SOCD clean, coin stretch.
// Optional autofire gating on fire A is built only when ARCADE_AUTOFIRE_EN is defined.

module arcade_input_lane #(
  parameter int COIN_PULSE = 24000
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] in_s1,
  input  logic        rot_en,
  input  logic        rot_acw,
  input  logic        af_gate,
  output logic [15:0] player,
  output logic        start,
  output logic        coin
);
  localparam int CW = $clog2(COIN_PULSE + 1);

  logic [3:0]    d, r;
  logic [CW-1:0] cnt;
  logic          coin_prev;

  // bit order {U,D,L,R}
  assign d = in_s1[3:0];
  always_comb begin
    r = d;
    if (rot_en) r = rot_acw ? {d[1], d[0], d[2], d[3]} : {d[0], d[1], d[3], d[2]};
    if (r[0] && r[1]) r[1:0] = 2'b00;
    if (r[2] && r[3]) r[3:2] = 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      player <= '0;
      start  <= 1'b0;
    end else begin
      player <= {6'b0, in_s1[9:5], in_s1[4] & af_gate, r};
      start  <= in_s1[10];
    end
  end

  // one pulse per rising edge; edges seen while counting are dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      coin_prev <= 1'b0;
    end else begin
      coin_prev <= in_s1[11];
      if (cnt != '0)                     cnt <= cnt - CW'(1);
      else if (in_s1[11] && !coin_prev)  cnt <= CW'(COIN_PULSE);
    end
  end

  assign coin = |cnt;
endmodule

module arcade_input_ctrl #(
  parameter int PLAYERS      = 2,
  parameter int COIN_PULSE   = 24000,
  parameter int AUTOFIRE_DIV = 800000
)(
  input  logic               clk,
  input  logic               reset,
  arcade_input_ctrl_if.slave io
);
  localparam int K_U = 0, K_D = 1, K_L = 2, K_R = 3, K_A = 4, K_B = 5, K_C = 6,
                 K_S0 = 7, K_C0 = 8, K_S1 = 9, K_C1 = 10;

  logic [10:0]               key_st;
  logic [PLAYERS-1:0][11:0]  joy_s1, slot, merged;
  logic [1:0][11:0]          kb;
  logic                      swap_s1, rot_s1;
  logic [1:0]                ori_s1;
  logic [PLAYERS-1:0]        af_gate;
  logic [PLAYERS-1:0][15:0]  pl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_st <= '0;
    end else if (io.key_strobe) begin
      case (io.key_code)
        8'h75: key_st[K_U]  <= io.key_pressed;
        8'h72: key_st[K_D]  <= io.key_pressed;
        8'h6B: key_st[K_L]  <= io.key_pressed;
        8'h74: key_st[K_R]  <= io.key_pressed;
        8'h14: key_st[K_A]  <= io.key_pressed;
        8'h11: key_st[K_B]  <= io.key_pressed;
        8'h29: key_st[K_C]  <= io.key_pressed;
        8'h16: key_st[K_S0] <= io.key_pressed;
        8'h2E: key_st[K_C0] <= io.key_pressed;
        8'h1E: key_st[K_S1] <= io.key_pressed;
        8'h36: key_st[K_C1] <= io.key_pressed;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      joy_s1  <= '0;
      swap_s1 <= 1'b0;
      rot_s1  <= 1'b0;
      ori_s1  <= 2'b00;
    end else begin
      for (int p = 0; p < PLAYERS; p++) joy_s1[p] <= io.joystick[32*p +: 12];
      swap_s1 <= io.joyswap;
      rot_s1  <= io.rotate;
      ori_s1  <= io.orientation;
    end
  end

  assign kb[0] = {key_st[K_C0], key_st[K_S0], 3'b000, key_st[K_C], key_st[K_B], key_st[K_A],
                  key_st[K_U], key_st[K_D], key_st[K_L], key_st[K_R]};
  assign kb[1] = {key_st[K_C1], key_st[K_S1], 10'b0};

  generate
    if (PLAYERS >= 2) begin : g_swap
      always_comb begin
        slot = joy_s1;
        if (swap_s1) begin
          slot[0] = joy_s1[1];
          slot[1] = joy_s1[0];
        end
      end
    end else begin : g_noswap
      assign slot = joy_s1;
      logic unused_swap;
      assign unused_swap = swap_s1;
    end
  endgenerate

`ifdef ARCADE_AUTOFIRE_EN
  localparam int AW = (AUTOFIRE_DIV > 2) ? $clog2(AUTOFIRE_DIV) : 1;
  logic [AW-1:0]      af_cnt;
  logic               af_phase;
  logic [PLAYERS-1:0] af_s1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
      af_s1    <= '0;
    end else begin
      af_s1 <= io.autofire;
      if (af_cnt == AW'(AUTOFIRE_DIV - 1)) begin
        af_cnt   <= '0;
        af_phase <= ~af_phase;
      end else begin
        af_cnt <= af_cnt + AW'(1);
      end
    end
  end
  assign af_gate = ~af_s1 | {PLAYERS{af_phase}};
`else
  localparam int unused_af_div = AUTOFIRE_DIV;
  logic unused_af;
  assign unused_af = ^io.autofire;
  assign af_gate   = '1;
`endif

  generate
    for (genvar p = 0; p < PLAYERS; p++) begin : g_lane
      logic unused_hi;
      assign unused_hi = ^io.joystick[32*p+12 +: 20];
      if (p < 2) begin : g_kb
        assign merged[p] = slot[p] | kb[p];
      end else begin : g_nokb
        assign merged[p] = slot[p];
      end
      arcade_input_lane #(.COIN_PULSE(COIN_PULSE)) u_lane (
        .clk     (clk),
        .reset   (reset),
        .in_s1   (merged[p]),
        .rot_en  (rot_s1 & ori_s1[0]),
        .rot_acw (ori_s1[1]),
        .af_gate (af_gate[p]),
        .player  (pl[p]),
        .start   (io.start_o[p]),
        .coin    (io.coin_o[p])
      );
    end
  endgenerate

  assign io.player_o = pl;
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Bench for arcade_input_ctrl (PLAYERS=2, COIN_PULSE=5, AUTOFIRE_DIV=4): vector table plus
// hand-written key/coin/reset sequences, expectations queued with a 2-clk due time.
module tb_arcade_input_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  arcade_input_ctrl_if #(.PLAYERS(2)) ifc();
  arcade_input_ctrl #(.PLAYERS(2), .COIN_PULSE(5), .AUTOFIRE_DIV(4)) dut (
    .clk(clk), .reset(reset), .io(ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    int          due;
    logic [31:0] pl;
    logic [1:0]  st;
    logic [1:0]  cn;
    string       nm;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [31:0] j0, j1;
    logic        swap, rot;
    logic [1:0]  ori;
    logic [31:0] ep;
    logic [1:0]  es;
  } vec_t;
  vec_t tbl[0:12];

  function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      if (e.due < cyc) check({e.nm, "_late"}, 64'(cyc), 64'(e.due));
      else check(e.nm, {ifc.player_o, ifc.start_o, ifc.coin_o}, {e.pl, e.st, e.cn});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // queue the output due for the inputs now applied, then advance one clock
  task automatic drive(input logic [31:0] ep, input logic [1:0] es, input logic [1:0] ec,
                       input string nm);
    exp_t e;
    e.due = cyc + 2; e.pl = ep; e.st = es; e.cn = ec; e.nm = nm;
    sbq.push_back(e);
    step();
    ifc.key_strobe = 1'b0;
  endtask

  task automatic key(input logic [7:0] c, input logic mk);
    ifc.key_strobe  = 1'b1;
    ifc.key_code    = c;
    ifc.key_pressed = mk;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{32'h0000_0011, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0000_0011, 2'b00};
    tbl[1]  = '{32'h0000_000B, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0000_0008, 2'b00}; // L|R|U
    tbl[2]  = '{32'h0000_000F, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 2'b00};
    tbl[3]  = '{32'h0000_0004, 32'h1, 1'b0, 1'b0, 2'b00, 32'h0001_0004, 2'b00};
    tbl[4]  = '{32'h0000_0001, 32'h0, 1'b0, 1'b1, 2'b01, 32'h0000_0008, 2'b00};
    tbl[5]  = '{32'h0000_0001, 32'h0, 1'b0, 1'b1, 2'b11, 32'h0000_0004, 2'b00};
    tbl[6]  = '{32'h0000_0001, 32'h0, 1'b0, 1'b1, 2'b00, 32'h0000_0001, 2'b00};
    tbl[7]  = '{32'h0000_0003, 32'h0, 1'b0, 1'b1, 2'b01, 32'h0000_0000, 2'b00};
    tbl[8]  = '{32'h0000_0008, 32'h0, 1'b0, 1'b1, 2'b01, 32'h0000_0002, 2'b00};
    tbl[9]  = '{32'h0000_0020, 32'h10, 1'b1, 1'b0, 2'b00, 32'h0020_0010, 2'b00};
    tbl[10] = '{32'h0000_0400, 32'h400, 1'b0, 1'b0, 2'b00, 32'h0000_0000, 2'b11};
    tbl[11] = '{32'hFFFF_F3F0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0000_03F0, 2'b00};
    tbl[12] = '{32'h0000_0000, 32'h8, 1'b0, 1'b1, 2'b11, 32'h0001_0000, 2'b00};

    reset = 1'b1;
    ifc.joystick = '0; ifc.key_strobe = 1'b0; ifc.key_pressed = 1'b0; ifc.key_code = '0;
    ifc.rotate = 1'b0; ifc.orientation = 2'b00; ifc.joyswap = 1'b0; ifc.autofire = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {ifc.player_o, ifc.start_o, ifc.coin_o}, 64'h0);

    // reset in the middle of a coin pulse
    reset = 1'b0;
    ifc.joystick = {32'h0, 32'h0000_0811};
    step(); step();
    check("t1_run_player", ifc.player_o[15:0], 16'h0011);
    check("t1_run_coin", ifc.coin_o, 2'b01);
    #3 reset = 1'b1;
    #1 check("t1_async_reset", {ifc.player_o, ifc.start_o, ifc.coin_o}, 64'h0);
    ifc.joystick = {32'h0, 32'h0000_0011};
    @(negedge clk) reset = 1'b0;
    step();
    check("t1_edge1", ifc.player_o, 32'h0);
    step();
    check("t1_edge2", ifc.player_o[15:0], 16'h0011);
    check("t1_coin_aborted", ifc.coin_o, 2'b00);

    for (int i = 0; i <= 12; i++) begin
      ifc.joystick = {tbl[i].j1, tbl[i].j0};
      ifc.joyswap = tbl[i].swap; ifc.rotate = tbl[i].rot; ifc.orientation = tbl[i].ori;
      drive(tbl[i].ep, tbl[i].es, 2'b00, $sformatf("vec%0d", i));
    end
    ifc.joystick = '0; ifc.joyswap = 1'b0; ifc.rotate = 1'b0; ifc.orientation = 2'b00;
    drive(0, 0, 0, "idle");

    // keyboard U held for 10 clocks
    key(8'h75, 1'b1); drive(32'h8, 0, 0, "key_u_make");
    for (int i = 0; i < 9; i++) drive(32'h8, 0, 0, "key_u_hold");
    key(8'h75, 1'b0); drive(0, 0, 0, "key_u_break");
    drive(0, 0, 0, "key_u_idle");
    key(8'h75, 1'b1); drive(32'h8, 0, 0, "key_u_make2");
    key(8'h75, 1'b1); drive(32'h8, 0, 0, "key_u_remake");
    key(8'h1C, 1'b1); drive(32'h8, 0, 0, "key_unmapped");
    key(8'h75, 1'b0); drive(0, 0, 0, "key_u_break2");

    // key release while joystick holds the same bit
    ifc.joystick = {32'h0, 32'h8};
    key(8'h75, 1'b1); drive(32'h8, 0, 0, "kj_make");
    for (int i = 0; i < 9; i++) drive(32'h8, 0, 0, "kj_hold");
    key(8'h75, 1'b0); drive(32'h8, 0, 0, "kj_break_held");
    drive(32'h8, 0, 0, "kj_after");
    ifc.joystick = '0; drive(0, 0, 0, "kj_release");

    key(8'h74, 1'b1); drive(32'h1, 0, 0, "key_r");
    key(8'h6B, 1'b1); drive(32'h0, 0, 0, "key_socd_lr");
    key(8'h74, 1'b0); drive(32'h2, 0, 0, "key_l_only");
    key(8'h6B, 1'b0); drive(0, 0, 0, "key_lr_off");
    key(8'h11, 1'b1); drive(32'h20, 0, 0, "key_fireb");
    key(8'h11, 1'b0); drive(0, 0, 0, "key_fireb_off");
    key(8'h16, 1'b1); drive(0, 2'b01, 0, "key_start0");
    key(8'h1E, 1'b1); drive(0, 2'b11, 0, "key_start1");
    key(8'h16, 1'b0); drive(0, 2'b10, 0, "key_start0_off");
    key(8'h1E, 1'b0); drive(0, 2'b00, 0, "key_start1_off");

    // coin held 20 clocks
    ifc.joystick = {32'h0, 32'h800};
    for (int i = 0; i < 20; i++) drive(0, 0, (i < 5) ? 2'b01 : 2'b00, "coin_hold");
    ifc.joystick = '0;
    repeat (3) drive(0, 0, 0, "coin_rel");
    // second edge mid-pulse does not extend
    for (int i = 0; i < 8; i++) begin
      ifc.joystick = (i == 0 || i == 2) ? {32'h0, 32'h800} : 64'h0;
      drive(0, 0, (i < 5) ? 2'b01 : 2'b00, "coin_noretrig");
    end
    for (int i = 0; i < 7; i++) begin
      ifc.joystick = (i < 2) ? {32'h0, 32'h800} : 64'h0;
      drive(0, 0, (i < 5) ? 2'b01 : 2'b00, "coin_second");
    end
    key(8'h36, 1'b1);
    for (int i = 0; i < 7; i++) drive(0, 0, (i < 5) ? 2'b10 : 2'b00, "key_coin1");
    key(8'h36, 1'b0); drive(0, 0, 0, "key_coin1_off");

`ifdef ARCADE_AUTOFIRE_EN
    begin
      logic [23:0] s;
      int last, nchg;
      ifc.joystick = {32'h10, 32'h10}; ifc.autofire = 2'b01;
      repeat (3) step();
      for (int i = 0; i < 24; i++) begin
        s[i] = ifc.player_o[4];
        check("af_p1_steady", ifc.player_o[20], 1'b1);
        step();
      end
      last = -1; nchg = 0;
      for (int i = 1; i < 24; i++) begin
        if (s[i] != s[i-1]) begin
          if (last >= 0) check("af_period", 64'(i - last), 64'd4);
          last = i; nchg++;
        end
      end
      check("af_toggles", 64'(nchg >= 4), 64'd1);
      ifc.joystick = '0; ifc.autofire = '0;
    end
`else
    ifc.joystick = {32'h0, 32'h10}; ifc.autofire = 2'b01;
    for (int i = 0; i < 8; i++) drive(32'h10, 0, 0, "af_ignored");
    ifc.joystick = '0; ifc.autofire = '0;
`endif

    repeat (4) step();
    check("sb_drain", 64'(sbq.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
